// File: rtl/regfile_read_port_pkg.sv
// Shared definitions for the integer register-file read port.
package regfile_read_port_pkg;

  localparam int XLEN = 32;  // data width
  localparam int NREG = 32;  // architectural registers, x0 hardwired to zero
  localparam int AW   = 5;   // register address width, clog2(NREG)

  typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register marking an
// outstanding write. A set from an accepted request wins over a same-cycle
// write-back clear of the same register; flush clears everything.
module regfile_scoreboard
  import regfile_read_port_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            set_en,
  input  reg_addr_t       set_addr,
  input  logic            clr_en,
  input  reg_addr_t       clr_addr,
  output logic [NREG-1:0] busy
);

  // Busy bits; x0 can never be busy because it is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (set_en && set_addr == reg_addr_t'(i)) begin
          busy[i] <= 1'b1;
        end else if (clr_en && clr_addr == reg_addr_t'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_read_port.sv
// Dual-source operand reader: owns the 32x32 register array and write-back
// port, bypasses same-cycle write-back data, stalls reads of busy registers,
// and returns both operands on a registered valid/ready response channel.
module regfile_read_port
  import regfile_read_port_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_rs1,
  input  logic [AW-1:0]   req_rs2,
  input  logic [AW-1:0]   req_rd,
  input  logic            req_rd_we,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rs1_data,
  output logic [XLEN-1:0] rsp_rs2_data,
  input  logic            wb_enable,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  // Write-back to x0 is discarded everywhere, so qualify it once.
  logic wb_we;
  logic hit_rs1, hit_rs2, hit_rd;
  logic clear_rs1, clear_rs2, rd_hazard, hazard;
  logic accept;
  logic rd_set;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign wb_we   = wb_enable && (wb_addr != '0);
  assign hit_rs1 = wb_we && (wb_addr == req_rs1);
  assign hit_rs2 = wb_we && (wb_addr == req_rs2);
  assign hit_rd  = wb_we && (wb_addr == req_rd);

  // Operand values: x0 reads zero, a matching write-back is bypassed.
  assign rs1_val = (req_rs1 == '0) ? '0 : (hit_rs1 ? wb_data : regs[req_rs1]);
  assign rs2_val = (req_rs2 == '0) ? '0 : (hit_rs2 ? wb_data : regs[req_rs2]);

  // A source is usable if it is x0, not busy, or resolved by this write-back.
  assign clear_rs1 = (req_rs1 == '0) || !busy[req_rs1] || hit_rs1;
  assign clear_rs2 = (req_rs2 == '0) || !busy[req_rs2] || hit_rs2;

  // A second in-flight write to the same destination is not allowed.
  assign rd_hazard = req_rd_we && (req_rd != '0) && busy[req_rd] && !hit_rd;
  assign hazard    = !clear_rs1 || !clear_rs2 || rd_hazard;

  // No req_valid term here, so ready never depends combinationally on valid.
  assign req_ready = !flush && !hazard && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rd_set    = accept && req_rd_we && (req_rd != '0);

  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .set_en   (rd_set),
    .set_addr (req_rd),
    .clr_en   (wb_we),
    .clr_addr (wb_addr),
    .busy     (busy)
  );

  // Register array write port; write-back still lands during a flush.
  // NOTE: the array is reset because reads after reset must return zero;
  // this keeps it in flops rather than an inferred RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Response register: load on accept, drain on consume, drop on flush.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_rs1_data <= '0;
      rsp_rs2_data <= '0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (accept) begin
      rsp_valid    <= 1'b1;
      rsp_rs1_data <= rs1_val;
      rsp_rs2_data <= rs2_val;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_read_port.md
# regfile_read_port

Dual-source operand reader for the integer register file. Accepts operand-fetch requests from decode with a valid/ready handshake and returns rs1/rs2 data one cycle later on a registered response channel. Owns the 32×32 architectural register array, the write-back port, and a busy-bit scoreboard that stalls reads of registers with an outstanding write. Sits between decode and execute, and is the consumer side of the enabled-write register storage.

## Interface
- XLEN, 32, data width
- NREG, 32, number of architectural registers; x0 is hardwired to zero
- AW, 5, register address width, clog2(NREG)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- req_valid  in  1  operand request present
- req_ready  out  1  request accepted when high with req_valid
- req_rs1, req_rs2  in  AW  source register addresses
- req_rd  in  AW  destination of the requesting instruction
- req_rd_we  in  1  requesting instruction will write req_rd
- rsp_valid  out  1  response data valid
- rsp_ready  in  1  execute consumes response
- rsp_rs1_data, rsp_rs2_data  out  XLEN  operand values
- wb_enable  in  1  write-back strobe
- wb_addr  in  AW  write-back register
- wb_data  in  XLEN  write-back value

## Operation
- Write-back: when wb_enable=1 and wb_addr≠0, regs[wb_addr]←wb_data and busy[wb_addr]←0. Writes to x0 are ignored. A write-back to a non-busy register still writes.
- Read value: a source of 0 reads 0. Otherwise, if wb_enable=1, wb_addr equals the source, and the source is nonzero, wb_data is bypassed. Otherwise regs[src] is read.
- Source is clear when it is 0, or busy[src]=0, or it is being written back this cycle (same wb match as the bypass).
- hazard = !clear(rs1) | !clear(rs2) | (req_rd_we & rd≠0 & busy[rd] & !(wb match on rd)).
- req_ready = !flush & !hazard & (!rsp_valid | rsp_ready).
- Accept (req_valid & req_ready):
  - capture both read values into the response registers and set rsp_valid=1;
  - if req_rd_we and rd≠0, set busy[rd]←1. A set wins over a same-cycle write-back clear of the same register.
- Response drains on rsp_valid & rsp_ready with no new accept, and rsp_valid←0. The response holds stable while rsp_valid & !rsp_ready.
- flush has priority over everything except write-back data:
  - rsp_valid←0 and all busy bits←0;
  - write-back still updates regs;
  - no request is accepted that cycle.

## Timing
- Latency: accept in cycle N gives rsp_valid=1 with data in cycle N+1.
- Throughput is one request per cycle when rsp_ready=1 and there are no hazards.
- req_ready is combinational from req_*, wb_*, flush, rsp_ready and state. There is no path from req_valid to req_ready.
- A write-back in cycle N is visible through the bypass in cycle N and through the array from cycle N+1.
- Async reset (rst_n low) clears regs to 0, busy to 0, rsp_valid to 0 and rsp_*_data to 0. Reset asserted mid-transaction discards the response.

## Structure
- Shared package holds XLEN, NREG, AW, and a typedef reg_addr_t of width AW.
- Sub-module regfile_scoreboard holds the NREG busy bits with set (accept), clear (write-back) and flush inputs and a set-over-clear rule. It exports the busy vector.
- The top level holds the register array, the bypass/read muxes, the hazard/ready logic, and the response register.

## Test plan
- Reset then basic read:
  - stimulus: wb x5←0xDEADBEEF, then request rs1=5, rs2=0;
  - required: rsp next cycle is 0xDEADBEEF / 0x00000000.
- RAW stall:
  - stimulus: accept request with rd=7, we=1, then request rs1=7;
  - required: req_ready=0 until wb x7←0x1234;
  - in the wb cycle: req_ready=1 and rsp_rs1_data=0x1234 next cycle (bypass).
- Backpressure:
  - stimulus: hold rsp_ready=0 for 3 cycles after an accept;
  - required: rsp data is stable, req_ready=0, and exactly one response is delivered when rsp_ready rises.
- x0 handling:
  - stimulus: wb x0←0xFFFFFFFF, request rs1=0, rd=0, we=1;
  - required: read is 0, no busy bit is set, and a following rs1=0 request is not stalled.
- Same-cycle set/clear:
  - stimulus: busy x3, wb x3 and accept rd=3, we=1 in the same cycle;
  - required: busy[3]=1 afterwards, and the next rs1=3 request stalls.
- Flush and async reset:
  - stimulus: flush with busy x9 and a pending response;
  - required: next cycle rsp_valid=0 and an rs1=9 request is accepted;
  - stimulus: drop rst_n mid-response;
  - required: rsp_valid=0 immediately.
